// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Digit select for one radix-4 recoded digit (magnitude class).
  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    N1,
    N2
  } digit_e;

  // The operands are extended by two bits, so there is one extra digit.
  function automatic int n_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_digit_recode.sv
// Radix-4 Booth recoder: maps the window {m[1], m[0], guard} to a digit.
module booth_digit_recode
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output digit_e     sel,
  output logic       neg
);

  // Standard radix-4 table; the negate flag only marks the -A / -2A digits.
  always_comb begin
    sel = ZERO;
    case (win)
      3'b001, 3'b010: sel = P1;
      3'b011:         sel = P2;
      3'b100:         sel = N2;
      3'b101, 3'b110: sel = N1;
      default:        sel = ZERO;
    endcase
    neg = (sel == N1) || (sel == N2);
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, start/done handshake.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int E  = WIDTH + 2;          // extended operand width
  localparam int AW = E + 2;              // accumulator holds +/-2A
  localparam int N  = n_digits(WIDTH);
  localparam int CW = $clog2(N);

  state_e          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [E-1:0]    mcand;
  logic [E-1:0]    mplr;
  logic            guard;
  logic [AW-1:0]   acc;

  logic [E-1:0]    a_ext, b_ext;
  digit_e          sel;
  logic            neg;
  logic [AW-1:0]   mag, addend, sum;
  logic [AW+E:0]   sh_in;
  logic signed [AW+E:0] sh;

  // Unsigned operands are zero-extended so both modes share the signed datapath.
  assign a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{2{is_signed & b[WIDTH-1]}}, b};

  booth_digit_recode u_recode (
    .win ({mplr[1:0], guard}),
    .sel (sel),
    .neg (neg)
  );

  // Digit magnitude, negation, accumulate and 2-bit arithmetic shift.
  always_comb begin
    mag = '0;
    case (sel)
      P1, N1:  mag = {{2{mcand[E-1]}}, mcand};
      P2, N2:  mag = {mcand[E-1], mcand, 1'b0};
      default: mag = '0;
    endcase
    addend = neg ? (~mag + AW'(1)) : mag;
    sum    = acc + addend;
    sh_in  = {sum, mplr, guard};
    sh     = $signed(sh_in) >>> 2;
  end

  // Next-state: DONE is a single writeback cycle that can also accept a start.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? RUN : IDLE;
      RUN:        state_nx = (cnt == '0) ? DONE : RUN;
      default:    state_nx = IDLE;
    endcase
  end

  // State register; clear beats a coincident start.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand load and one Booth step per RUN cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      mcand <= '0;
      mplr  <= '0;
      guard <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else if (state != RUN && start) begin
      mcand <= a_ext;
      mplr  <= b_ext;
      guard <= 1'b0;
      acc   <= '0;
      cnt   <= CW'(N - 1);
    end else if (state == RUN) begin
      {acc, mplr, guard} <= sh;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  // Registered outputs: busy mirrors RUN, result and done are written out of DONE.
  always_ff @(posedge clock) begin
    if (clear) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state == DONE);
      if (state == DONE) product <= {acc[WIDTH-3:0], mplr};
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Scoreboard bench for booth_seq_mul (WIDTH=32 directed, WIDTH=8 model-checked).
module tb_booth_seq_mul;

  logic        clock = 1'b0;
  logic        clear, start, is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  logic        start8, s8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];

  always #5 clock = ~clock;

  booth_seq_mul #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  booth_seq_mul #(.WIDTH(8)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .is_signed(s8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse pops the oldest expected product.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done32: got product %h with empty queue", product);
      end else chk("product32", product, q32.pop_front());
    end
  end

  always @(negedge clock) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done8: got product %h with empty queue", product8);
      end else chk("product8", {48'b0, product8}, {48'b0, q8.pop_front()});
    end
  end

  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp);
    @(negedge clock);
    is_signed = s; a = x; b = y; start = 1'b1;
    q32.push_back(exp);
    @(posedge clock);
  endtask

  // Called right after the start edge; checks latency, busy length, optional hold.
  task automatic wait_done(input string name, input int poke_at, input bit hold_chk,
                           input logic [63:0] hold);
    int lat = -1;
    int bc  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      if (i == poke_at) begin
        start = 1'b1; a = 32'h5; b = 32'h9; is_signed = ~is_signed;
      end
      if (i == poke_at + 1) start = 1'b0;
      if (busy) bc++;
      if (done && i > 0) begin
        lat = i;
        break;
      end
      if (hold_chk) chk({name, "_hold"}, product, hold);
      @(posedge clock);
    end
    chk({name, "_latency"}, 64'(lat), 64'd18);
    chk({name, "_busy_cycles"}, 64'(bc), 64'd17);
  endtask

  task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] e;
    int lat = -1;
    if (s) e = $signed(x) * $signed(y);
    else   e = x * y;
    @(negedge clock);
    s8 = s; a8 = x; b8 = y; start8 = 1'b1;
    q8.push_back(e);
    @(posedge clock);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (i == 0) start8 = 1'b0;
      if (done8) begin
        lat = i;
        break;
      end
      @(posedge clock);
    end
    chk("latency8", 64'(lat), 64'd6);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_product", product, 64'd0);
    chk("reset_product8", {48'b0, product8}, 64'd0);
    clear = 1'b0;

    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_done("s_minsq", -1, 1'b0, 64'd0);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("u_maxsq", -1, 1'b0, 64'd0);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    wait_done("s_m1sq", -1, 1'b1, 64'hFFFF_FFFE_0000_0001);
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done("s_m1x2", -1, 1'b0, 64'd0);
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("s_7xm3", -1, 1'b0, 64'd0);
    issue(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    wait_done("s_maxsq", -1, 1'b0, 64'd0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
    wait_done("u_maxx2", -1, 1'b0, 64'd0);

    // Start and operand changes mid-run must not disturb the result.
    issue(1'b1, 32'h0000_0002, 32'h0000_0003, 64'd6);
    wait_done("ignored_start", 4, 1'b0, 64'd0);

    // Back-to-back: start in the DONE state cycle (first cycle busy drops).
    issue(1'b0, 32'h0000_0003, 32'h0000_0004, 64'd12);
    begin
      int idx = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (i == 0) start = 1'b0;
        if (!busy) begin
          idx = i;
          break;
        end
        @(posedge clock);
      end
      chk("b2b_done_state_index", 64'(idx), 64'd17);
    end
    is_signed = 1'b0; a = 32'h6; b = 32'h7; start = 1'b1;
    q32.push_back(64'd42);
    @(posedge clock);
    wait_done("b2b_second", -1, 1'b1, 64'd12);

    // Clear in the fifth RUN cycle discards everything.
    @(negedge clock);
    is_signed = 1'b1; a = 32'h3; b = 32'h5; start = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      if (i == 4) clear = 1'b1;
      @(posedge clock);
    end
    @(negedge clock);
    clear = 1'b0;
    chk("clear_busy", {63'b0, busy}, 64'd0);
    chk("clear_done", {63'b0, done}, 64'd0);
    chk("clear_product", product, 64'd0);
    repeat (25) @(negedge clock);
    issue(1'b1, 32'h0000_0003, 32'h0000_0005, 64'd15);
    wait_done("after_clear", -1, 1'b1, 64'd0);

    // WIDTH=8: directed corners, then model-checked random operands.
    run8(1'b1, 8'h80, 8'h80);
    run8(1'b0, 8'hFF, 8'hFF);
    run8(1'b1, 8'hFF, 8'hFF);
    run8(1'b1, 8'h7F, 8'h80);
    for (int i = 0; i < 300; i++)
      run8(1'(i % 2), 8'($urandom), 8'($urandom));

    repeat (5) @(negedge clock);
    chk("queue32_drained", 64'(q32.size()), 64'd0);
    chk("queue8_drained", 64'(q8.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
